// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: it produces one quotient bit per cycle
// from the operand magnitudes and applies a sign fix-up on the final step.
module div_unit #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    DBZ  = 2'd1,
    ON   = 2'd2,
    END  = 2'd3
  } state_t;

  state_t            r_state, w_state_n;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic [2*DW:0]     r_w, w_w_n;
  logic [DW-1:0]     r_divisor, w_divisor_n;
  logic              r_signed, w_signed_n;
  logic              r_sign1, w_sign1_n;
  logic              r_sign2, w_sign2_n;
  logic [2*DW-1:0]   r_result, w_result_n;
  logic              r_ready, w_ready_n;

  logic [DW-1:0]     w_mag1, w_mag2;
  logic [2*DW:0]     w_shift, w_step;
  logic [DW:0]       w_diff;
  logic              w_borrow;
  logic [DW-1:0]     w_quo, w_rem;
  logic              w_abort;

  assign w_mag1 = (signed_div_i && opdata1_i[DW-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign w_mag2 = (signed_div_i && opdata2_i[DW-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

  // The top bit of W is always zero before a shift because the partial remainder stays below the divisor.
  assign w_shift  = r_w << 1;
  assign w_borrow = w_shift[2*DW:DW] < {1'b0, r_divisor};
  assign w_diff   = w_shift[2*DW:DW] - {1'b0, r_divisor};
  assign w_step   = w_borrow ? w_shift : {w_diff, w_shift[DW-1:1], 1'b1};

  assign w_quo = (r_signed && (r_sign1 ^ r_sign2)) ? (~w_step[DW-1:0] + 1'b1) : w_step[DW-1:0];
  assign w_rem = (r_signed && r_sign1) ? (~w_step[2*DW-1:DW] + 1'b1) : w_step[2*DW-1:DW];

  assign w_abort = annul_i || !start_i;

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_w_n       = r_w;
    w_divisor_n = r_divisor;
    w_signed_n  = r_signed;
    w_sign1_n   = r_sign1;
    w_sign2_n   = r_sign2;
    w_result_n  = r_result;
    w_ready_n   = r_ready;

    case (r_state)
      FREE: begin
        w_ready_n  = 1'b0;
        w_result_n = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_n = DBZ;
          end else begin
            w_state_n   = ON;
            w_cnt_n     = '0;
            w_w_n       = {{(DW+1){1'b0}}, w_mag1};
            w_divisor_n = w_mag2;
            w_signed_n  = signed_div_i;
            w_sign1_n   = opdata1_i[DW-1];
            w_sign2_n   = opdata2_i[DW-1];
          end
        end
      end
      DBZ: begin
        w_result_n = '0;
        if (w_abort) begin
          w_state_n = FREE;
          w_ready_n = 1'b0;
        end else begin
          w_state_n = END;
          w_ready_n = 1'b1;
        end
      end
      ON: begin
        if (w_abort) begin
          w_state_n  = FREE;
          w_ready_n  = 1'b0;
          w_result_n = '0;
        end else begin
          w_w_n   = w_step;
          w_cnt_n = r_cnt + CW'(1);
          if (r_cnt == CW'(DW - 1)) begin
            w_state_n  = END;
            w_ready_n  = 1'b1;
            w_result_n = {w_rem, w_quo};
          end
        end
      end
      END: begin
        if (w_abort) begin
          w_state_n  = FREE;
          w_ready_n  = 1'b0;
          w_result_n = '0;
        end
      end
      default: begin
        w_state_n  = FREE;
        w_ready_n  = 1'b0;
        w_result_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FREE;
      r_cnt     <= '0;
      r_w       <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_w       <= w_w_n;
      r_divisor <= w_divisor_n;
      r_signed  <= w_signed_n;
      r_sign1   <= w_sign1_n;
      r_sign2   <= w_sign2_n;
      r_result  <= w_result_n;
      r_ready   <= w_ready_n;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider feeding the execute stage of the MIPS pipeline; serves DIV and DIVU.
- The execute stage holds start_i high and stalls the pipeline until ready_o rises. It then drops start_i and writes result_o into HI/LO, with HI = remainder and LO = quotient.
- Uses one-bit-per-cycle restoring division on operand magnitudes, with a final sign correction for signed division.

Parameters:
- DW, 32, operand width. Result is 2*DW bits; the iteration count equals DW.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at the accept edge
- opdata1_i  in  DW  dividend; sampled at the accept edge
- opdata2_i  in  DW  divisor; sampled at the accept edge
- start_i  in  1  request; held high by the execute stage until it sees ready_o
- annul_i  in  1  cancel the operation in progress (pipeline flush)
- result_o  out  2*DW  {remainder[DW-1:0], quotient[DW-1:0]}; valid only while ready_o = 1
- ready_o  out  1  result valid

Behaviour:
- Reset: synchronous. When rst = 1 at an edge: state = FREE, ready_o = 0, result_o = 0, counter = 0. Reset mid-operation discards all partial work.
- All outputs are registered. There are no combinational input-to-output paths.
- States are FREE, DBZ, ON and END.
- FREE:
  - start_i = 1, annul_i = 0, opdata2_i = 0: go to DBZ.
  - start_i = 1, annul_i = 0, opdata2_i != 0: go to ON, counter = 0.
  - On entering ON, latch magnitudes: for a signed op, a negative operand is replaced by its two's complement; otherwise the operand is used as-is.
  - Also latch signed_div_i and both operand sign bits.
  - 0x80000000 has magnitude 0x80000000 when read as unsigned.
  - Any other input combination: stay in FREE, ready_o = 0.
- DBZ: on the next edge, result_o = 0 and ready_o = 1; go to END.
- ON:
  - Working register W is 2*DW+1 bits, initialised to {0, 0...0, |dividend|}.
  - Each edge performs one step:
    - shift W left by 1;
    - compute diff = W[2DW:DW] - {0, |divisor|} (DW+1 bits);
    - if there is no borrow, W[2DW:DW] = diff and W[0] = 1;
    - increment the counter.
  - The step with counter = DW-1 is the last one. At that same edge, load result_o with the sign-corrected result, set ready_o = 1 and go to END.
  - Sign correction applies only to signed ops:
    - quotient is negated if the dividend sign differs from the divisor sign;
    - remainder is negated if the dividend is negative.
  - Abort: if annul_i = 1 or start_i = 0 at any ON edge, go to FREE, ready_o = 0, result_o = 0. The iteration is not performed.
- Latency: with accept edge N, steps occur at edges N+1..N+DW. ready_o is high after edge N+DW (N+32 for the default DW). For divide-by-zero, ready_o is high after edge N+1.
- END:
  - Hold result_o and ready_o = 1 while start_i = 1.
  - When start_i = 0 at an edge: go to FREE, ready_o = 0, result_o = 0.
  - annul_i in END has the same effect as start_i = 0.
- Simultaneous events:
  - rst has priority over everything.
  - annul_i has priority over start_i in every state.
  - start_i while in ON/DBZ/END is not a new request; no re-accept happens until the block is back in FREE.
- Back-to-back operations: a new request is accepted at the first FREE edge with start_i = 1. That is at least one cycle after ready_o falls, because the execute stage must drop start_i.
- Operands changing while in ON are ignored; only the latched values are used.

Test Plan:
- Unsigned: opdata1 = 0xFFFFFFFF, opdata2 = 0x10, signed = 0, start held → ready_o after exactly 32 edges past accept; result_o = {0x0000000F, 0x0FFFFFFF}. Drop start → ready_o = 0 the next edge.
- Signed: opdata1 = 0xFFFFFFF9 (-7), opdata2 = 2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Also 7 / -2 → q = 0xFFFFFFFD, r = 0x00000001.
- Signed overflow corner: 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0. Unsigned 0x80000000 / 0xFFFFFFFF → q = 0, r = 0x80000000.
- Divide by zero: opdata2 = 0 with start → ready_o after 2 edges (accept + DBZ), result_o = 0. ready_o stays high until start_i drops.
- Abort: assert annul_i at step 10 of a division → FREE next edge, ready_o never rises. Restart 100/7 unsigned → {2, 14} after 32 steps.
- Reset mid-ON (at step 20) → ready_o = 0, result_o = 0. A following start of 9/3 → {0, 3} with full 32-step latency; no stale state carried over.
